// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port arbiter.
// master = requesters plus memory model, slave = the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer sharing one single-ported memory between NUM_REQ requesters.
// One access in flight at a time: IDLE -> ISSUE -> WAIT -> DONE; all outputs registered.
module mem_port_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    win_reg, win_next;
    logic [IDX_W-1:0]    rr_reg, rr_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                we_lat_reg, we_lat_next;
    logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]  done_reg, done_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                mem_en_reg, mem_en_next;
    logic                mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Winner search: first active request at or above the RR pointer, wrapping.
    logic              scan_found;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W:0]    pos_sum;
    logic [IDX_W-1:0]  pos;

    always_comb begin
        scan_found = 1'b0;
        scan_idx   = rr_reg;
        pos_sum    = '0;
        pos        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_sum = {1'b0, rr_reg} + (IDX_W+1)'(k);
            if (pos_sum >= (IDX_W+1)'(NUM_REQ)) begin
                pos_sum = pos_sum - (IDX_W+1)'(NUM_REQ);
            end
            pos = pos_sum[IDX_W-1:0];
            if (!scan_found && bus.req[pos]) begin
                scan_found = 1'b1;
                scan_idx   = pos;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        win_next       = win_reg;
        rr_next        = rr_reg;
        cnt_next       = cnt_reg;
        we_lat_next    = we_lat_reg;
        gnt_next       = '0;
        done_next      = '0;
        rdata_next     = rdata_reg;
        mem_en_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            IDLE: begin
                // Port values are loaded here so they are visible during ISSUE.
                if (scan_found) begin
                    state_next     = ISSUE;
                    win_next       = scan_idx;
                    we_lat_next    = bus.we[scan_idx];
                    gnt_next       = NUM_REQ'(1) << scan_idx;
                    mem_en_next    = 1'b1;
                    mem_we_next    = bus.we[scan_idx];
                    mem_addr_next  = addr_arr[scan_idx];
                    mem_wdata_next = wdata_arr[scan_idx];
                end
            end
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = CNT_W'(MEM_LATENCY - 1);
                rr_next    = (win_reg == IDX_W'(NUM_REQ - 1)) ? '0 : win_reg + 1'b1;
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    if (!we_lat_reg) begin
                        rdata_next = bus.mem_rdata;
                    end
                    done_next  = NUM_REQ'(1) << win_reg;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            win_reg       <= '0;
            rr_reg        <= '0;
            cnt_reg       <= '0;
            we_lat_reg    <= 1'b0;
            gnt_reg       <= '0;
            done_reg      <= '0;
            rdata_reg     <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            win_reg       <= win_next;
            rr_reg        <= rr_next;
            cnt_reg       <= cnt_next;
            we_lat_reg    <= we_lat_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            rdata_reg     <= rdata_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.done      = done_reg;
    assign bus.rdata     = rdata_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level model predicts grant order,
// timing and read data; a negedge monitor compares the DUT every cycle.
module tb_mem_port_arbiter;
    localparam int NR  = 4;
    localparam int AW  = 15;
    localparam int DW  = 64;
    localparam int LAT = 3;
    localparam int PER = LAT + 3;
    localparam logic [DW-1:0] JUNK = 64'h0BAD_0BAD_0BAD_0BAD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        chk_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp_v);
    endtask

    // Initial memory contents for never-written, non-preloaded words.
    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {16'hA5C3, 1'b0, a, ~{17'h0, a}};
    endfunction

    logic [DW-1:0] preload_mem [int];

    // Memory macro: reads return data LAT cycles after the enable cycle.
    logic [DW-1:0] env_mem     [2**AW];
    bit            env_written [2**AW];
    logic [DW-1:0] rd_pipe     [LAT];

    function automatic logic [DW-1:0] env_read(input logic [AW-1:0] a);
        if (env_written[a]) return env_mem[a];
        if (preload_mem.exists(int'(a))) return preload_mem[int'(a)];
        return dflt(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            env_mem[bus.mem_addr]     <= bus.mem_wdata;
            env_written[bus.mem_addr] <= 1'b1;
        end
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? env_read(bus.mem_addr) : JUNK;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[LAT-1];

    // Reference model state
    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] model_rdata = '0;
    int            ptr = 0;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        if (preload_mem.exists(int'(a))) return preload_mem[int'(a)];
        return dflt(a);
    endfunction

    typedef struct {
        int            idx;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            cyc;
    } gexp_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] rdata;
        int            cyc;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    // Monitor
    always @(negedge clk) begin : monitor
        gexp_t g;
        dexp_t d;
        if (!rst) begin
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                g = gq.pop_front();
                chk("gnt", bus.gnt, NR'(1) << g.idx);
                chk("mem_en_issue", bus.mem_en, 1);
                chk("mem_we_issue", bus.mem_we, g.we);
                chk("mem_addr", bus.mem_addr, g.addr);
                chk("mem_wdata", bus.mem_wdata, g.wdata);
                chk("busy_issue", bus.busy, 1);
            end else begin
                chk("gnt_quiet", bus.gnt, 0);
                chk("mem_en_quiet", bus.mem_en, 0);
                chk("mem_we_quiet", bus.mem_we, 0);
            end
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                d = dq.pop_front();
                chk("done", bus.done, NR'(1) << d.idx);
                chk("rdata", bus.rdata, d.rdata);
                chk("busy_done", bus.busy, 1);
            end else begin
                chk("done_quiet", bus.done, 0);
            end
        end
    end

    // Per-requester stimulus fields for the next batch
    logic          b_we    [NR];
    logic [AW-1:0] b_addr  [NR];
    logic [DW-1:0] b_wdata [NR];
    int            b_rep   [NR];
    logic          b_drop  [NR];

    task automatic set_b(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int rep, input logic drop);
        b_we[i] = w; b_addr[i] = a; b_wdata[i] = d; b_rep[i] = rep; b_drop[i] = drop;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_mem_en"}, bus.mem_en, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ptr = 0;
        model_rdata = '0;
        gq.delete();
        dq.delete();
    endtask

    // Raise the masked requests together; each holds req for b_rep accesses.
    task automatic run_batch(input logic [NR-1:0] mask);
        int rem[NR];
        int drv_rem[NR];
        int k, t0, budget, win, left, total;
        gexp_t g;
        dexp_t d;
        @(negedge clk);
        t0 = cyc;
        total = 0;
        for (int i = 0; i < NR; i++) begin
            rem[i] = mask[i] ? b_rep[i] : 0;
            drv_rem[i] = rem[i];
            total += rem[i];
        end
        k = 0;
        while (total > 0) begin
            win = -1;
            for (int j = 0; j < NR; j++) begin
                int p;
                p = (ptr + j) % NR;
                if (win < 0 && rem[p] > 0) win = p;
            end
            g.idx = win; g.we = b_we[win]; g.addr = b_addr[win]; g.wdata = b_wdata[win];
            g.cyc = t0 + 1 + k * PER;
            gq.push_back(g);
            if (b_we[win]) model_mem[int'(b_addr[win])] = b_wdata[win];
            else model_rdata = model_read(b_addr[win]);
            d.idx = win; d.rdata = model_rdata; d.cyc = t0 + 2 + LAT + k * PER;
            dq.push_back(d);
            rem[win]--;
            total--;
            ptr = (win + 1) % NR;
            k++;
        end
        for (int i = 0; i < NR; i++) begin
            if (mask[i]) begin
                bus.we[i] = b_we[i];
                bus.addr[i*AW +: AW] = b_addr[i];
                bus.wdata[i*DW +: DW] = b_wdata[i];
                bus.req[i] = 1'b1;
            end
        end
        left = k;
        budget = k * PER + 8;
        while (left > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            for (int i = 0; i < NR; i++) begin
                if (bus.gnt[i] && b_drop[i] && drv_rem[i] == 1) bus.req[i] = 1'b0;
                if (bus.done[i] && drv_rem[i] > 0) begin
                    drv_rem[i]--;
                    left--;
                    if (drv_rem[i] == 0) bus.req[i] = 1'b0;
                end
            end
        end
        if (left > 0) begin
            chk("batch_complete", 0, 1);
            do_reset();
        end
    endtask

    task automatic reset_mid_access();
        gexp_t g;
        int c;
        @(negedge clk);
        c = cyc;
        bus.we[0] = 1'b0;
        bus.addr[0 +: AW] = 15'd1000;
        bus.wdata[0 +: DW] = '0;
        bus.req[0] = 1'b1;
        g.idx = 0; g.we = 1'b0; g.addr = 15'd1000; g.wdata = '0; g.cyc = c + 1;
        gq.push_back(g);
        @(negedge clk);
        bus.req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b0;
        ptr = 0;
        model_rdata = '0;
        repeat (LAT + 3) begin
            @(negedge clk);
            chk("no_done_after_rst", bus.done, 0);
        end
    endtask

    logic [AW-1:0] addr_pool [8] = '{15'd0, 15'd1, 15'd2, 15'd77, 15'd1000,
                                     15'd4095, 15'd12345, 15'd32767};

    initial begin
        logic [NR-1:0] mask;
        bus.req = '0;
        bus.we = '0;
        bus.addr = '0;
        bus.wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Contention from reset release: expect 0,1,0,1
        set_b(0, 1'b0, 15'd1, '0, 2, 1'b0);
        set_b(1, 1'b0, 15'd2, '0, 2, 1'b0);
        run_batch(4'b0011);

        // Single read of preloaded word 0
        preload_mem[0] = 64'h1111_2222_3333_4444;
        set_b(0, 1'b0, 15'd0, '0, 1, 1'b0);
        run_batch(4'b0001);

        // Write then read back at the top address
        set_b(1, 1'b1, 15'd32767, 64'hDEAD_BEEF_0000_7FFF, 1, 1'b0);
        run_batch(4'b0010);
        set_b(1, 1'b0, 15'd32767, '0, 1, 1'b0);
        run_batch(4'b0010);

        // Pointer wrap: 3 first, then 0 and 2 together
        set_b(3, 1'b0, 15'd5, '0, 1, 1'b0);
        run_batch(4'b1000);
        set_b(0, 1'b0, 15'd6, '0, 1, 1'b0);
        set_b(2, 1'b1, 15'd7, 64'h0123_4567_89AB_CDEF, 1, 1'b0);
        run_batch(4'b0101);

        // Read at 4095, done LAT+2 cycles after request
        set_b(2, 1'b0, 15'd4095, '0, 1, 1'b0);
        run_batch(4'b0100);

        // Reset during WAIT, then pointer-0 arbitration between 1 and 3
        reset_mid_access();
        set_b(1, 1'b0, 15'd1000, '0, 1, 1'b0);
        set_b(3, 1'b1, 15'd1000, 64'hFEED_FACE_CAFE_0001, 1, 1'b1);
        run_batch(4'b1010);

        // Randomized batches
        repeat (30) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                set_b(i, 1'($urandom_range(0, 1)), addr_pool[$urandom_range(0, 7)],
                      {$urandom, $urandom}, $urandom_range(1, 2),
                      ($urandom_range(0, 3) == 0));
            end
            run_batch(mask);
        end

        repeat (4) @(negedge clk);
        chk("gnt_queue_drained", gq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
